// File: rtl/sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_if
//
// Purpose: This interface bundles every handshake and pin-level bus signal of
//          sram_port_arbiter: the fetch port, the data port, the pipeline stall
//          request and the external SRAM pins.
//
// Modports:
//   slave  - the arbiter's view. It samples the requests and SRAM read data,
//            and drives the completions, the stall request and the SRAM pins.
//   master - the environment's view: the pipeline stages plus the SRAM device.
//
// Signals:
//   if_req/if_addr            fetch request and word-aligned byte address
//   if_rdata/if_ready         fetched word and its one-cycle completion pulse
//   d_req/d_we/d_sel          data request, store flag, store byte enables
//   d_addr/d_wdata            data byte address and store data
//   d_rdata/d_ready           load data and its one-cycle completion pulse
//   stall_req                 pipeline freeze request
//   sram_ce_n/oe_n/we_n/be_n  active-low SRAM strobes and byte enables
//   sram_addr/sram_wdata      SRAM word address and write data
//   sram_rdata                SRAM read data
// -----------------------------------------------------------------------------
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 20
);
   // Fetch port
   logic              if_req;
   logic [31:0]       if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;

   // Data port
   logic              d_req;
   logic              d_we;
   logic [3:0]        d_sel;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ready;

   // Pipeline control
   logic              stall_req;

   // SRAM pins
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic [3:0]        sram_be_n;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_ready,
      input  d_req, d_we, d_sel, d_addr, d_wdata,
      output d_rdata, d_ready,
      output stall_req,
      output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_wdata,
      input  sram_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_ready,
      output d_req, d_we, d_sel, d_addr, d_wdata,
      input  d_rdata, d_ready,
      input  stall_req,
      input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose: This block shares one single-ported asynchronous SRAM between the
//          instruction fetch stage and the load/store stage. Each access runs
//          through the sequence IDLE -> ACCESS (WAIT_CYCLES strobe cycles) ->
//          DONE. In DONE the block returns a one-cycle ready pulse to the
//          requester that was granted. Data requests have fixed priority over
//          fetch requests, because the data request belongs to the older
//          instruction.
//
// Parameters:
//   WAIT_CYCLES  SRAM strobe cycles per access. The legal range is 1..15.
//   ADDR_W       SRAM word-address width. The byte address bits
//                [ADDR_W+1:2] are used. ADDR_W must be at most 30.
//
// Ports:
//   clk            core clock. All state changes on the rising edge.
//   rst            asynchronous, active-low reset
//   bus            sram_port_arbiter_if.slave, which carries the fetch port,
//                  the data port, stall_req and the SRAM pins
//   perf_if_stall  count of cycles in which fetch is blocked
//   perf_d_acc     count of completed data accesses
//
// Build option:
//   SRAM_ARB_PERF_EN  When this macro is defined, the two performance
//                     counters are built. When it is not defined, both perf
//                     outputs are tied to zero.
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 20
) (
   input  logic                clk,
   input  logic                rst,
   sram_port_arbiter_if.slave  bus,
   output logic [31:0]         perf_if_stall,
   output logic [31:0]         perf_d_acc
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // The strobe counter counts down from WAIT_CYCLES-1 to 0, so ACCESS lasts
   // exactly WAIT_CYCLES cycles.
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic              gnt_data_q, gnt_data_d;   // 1 = data port owns the access
   logic              we_q, we_d;
   logic [3:0]        be_n_q, be_n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;

   logic              if_ready_w;
   logic              d_ready_w;

   // Address bits outside the word-address window are ignored by design.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                               bus.d_addr[31:ADDR_W+2],  bus.d_addr[1:0]};

   // ---------------------------------------------------------------------------
   // State and access registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         gnt_data_q <= 1'b0;
         we_q       <= 1'b0;
         be_n_q     <= 4'hF;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         gnt_data_q <= gnt_data_d;
         we_q       <= we_d;
         be_n_q     <= be_n_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic: arbitration, access latch, strobe countdown, capture
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      gnt_data_d = gnt_data_q;
      we_d       = we_q;
      be_n_d     = be_n_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.d_req) begin
               state_d    = S_ACCESS;
               gnt_data_d = 1'b1;
               we_d       = bus.d_we;
               // All byte lanes are enabled for reads. Stores drive only the
               // selected lanes.
               be_n_d     = bus.d_we ? ~bus.d_sel : 4'b0000;
               addr_d     = bus.d_addr[ADDR_W+1:2];
               if (bus.d_we) begin
                  wdata_d = bus.d_wdata;
               end
               cnt_d      = CNT_INIT;
            end else if (bus.if_req) begin
               state_d    = S_ACCESS;
               gnt_data_d = 1'b0;
               we_d       = 1'b0;
               be_n_d     = 4'b0000;
               addr_d     = bus.if_addr[ADDR_W+1:2];
               cnt_d      = CNT_INIT;
            end
         end

         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               // The SRAM output is stable by the last strobe cycle. Read data
               // is captured only for the requester that owns the access, so
               // the other requester's read register keeps its old value.
               if (!we_q) begin
                  if (gnt_data_q) begin
                     d_rdata_d = bus.sram_rdata;
                  end else begin
                     if_rdata_d = bus.sram_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // The strobes are decoded from the registered state. Because of this, an
   // asynchronous reset releases them in the same cycle it is applied.
   // sram_addr and sram_wdata stay at their registered values during DONE.
   // This gives one cycle of address and data hold after we_n rises.
   assign if_ready_w = (state_q == S_DONE) && !gnt_data_q;
   assign d_ready_w  = (state_q == S_DONE) &&  gnt_data_q;

   assign bus.if_ready   = if_ready_w;
   assign bus.d_ready    = d_ready_w;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_rdata    = d_rdata_q;

   assign bus.sram_ce_n  = (state_q != S_ACCESS);
   assign bus.sram_oe_n  = !((state_q == S_ACCESS) && !we_q);
   assign bus.sram_we_n  = !((state_q == S_ACCESS) &&  we_q);
   assign bus.sram_be_n  = (state_q == S_ACCESS) ? be_n_q : 4'hF;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = wdata_q;

   assign bus.stall_req  = (bus.if_req && !if_ready_w) || (bus.d_req && !d_ready_w);

`ifdef SRAM_ARB_PERF_EN
   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   logic [31:0] perf_if_stall_q;
   logic [31:0] perf_d_acc_q;
   logic        fetch_served;

   // Fetch counts as served in two cases. The first is while it owns an access.
   // The second is the IDLE cycle in which fetch wins arbitration, which
   // happens when no data request is pending.
   assign fetch_served = ((state_q != S_IDLE) && !gnt_data_q) ||
                         ((state_q == S_IDLE) && !bus.d_req);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_if_stall_q <= '0;
         perf_d_acc_q    <= '0;
      end else begin
         if (bus.if_req && !fetch_served) begin
            perf_if_stall_q <= perf_if_stall_q + 32'd1;
         end
         if (d_ready_w) begin
            perf_d_acc_q <= perf_d_acc_q + 32'd1;
         end
      end
   end

   assign perf_if_stall = perf_if_stall_q;
   assign perf_d_acc    = perf_d_acc_q;
`else
   assign perf_if_stall = 32'h0;
   assign perf_d_acc    = 32'h0;
`endif

endmodule
